// File: rtl/ydm_pkg.sv
// Shared definitions for the ydm data-memory stage: funct3 codes, FSM states,
// byte-enable base patterns and the funct3 legality helper.
package ydm_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } ydm_state_e;

  // Stores only have signed-width codes; the unsigned variants are load-only.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/ydm_lane_align.sv
// Byte-lane steering for the ydm stage: byte enables, store-data replication
// and load lane extraction with sign/zero extension.
module ydm_lane_align
  import ydm_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] m_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = m_rdata_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? m_rdata_i[31:16] : m_rdata_i[15:0];

  // funct3[2] marks the unsigned load variants; low bits give the width.
  always_comb begin
    be_o    = BE_W;
    wdata_o = wdata_i;
    rdata_o = m_rdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o    = BE_B << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        be_o    = BE_H << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = funct3_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be_o    = BE_W;
        wdata_o = wdata_i;
        rdata_o = m_rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/ydm_stage.sv
// Data-memory stage: one load/store per accepted request over a req/ack bus
// with timeout. Define YDM_MISALIGN_CHK_EN to reject misaligned accesses.
module ydm_stage
  import ydm_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic        out_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  ydm_state_e    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          is_mem, acc_err, misalign;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata, lane_rdata;

  ydm_lane_align u_align (
    .funct3_i  (f3_q),
    .off_i     (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .m_rdata_i (m_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

`ifdef YDM_MISALIGN_CHK_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign is_mem  = mem_read | mem_write;
  assign acc_err = (mem_read & mem_write) ||
                   (is_mem && !f3_legal(funct3, mem_write)) ||
                   (is_mem && misalign);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d  = addr;
          wdata_d = wdata;
          f3_d    = funct3;
          we_d    = mem_write;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = acc_err;
          state_d = (is_mem && !acc_err) ? REQ : RESP;
        end
      end
      REQ: begin
        if (m_ack) begin
          state_d = RESP;
          rdata_d = we_q ? 32'h0 : lane_rdata;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs come straight from state and held registers, so they stay
  // stable through REQ and drop the instant reset hits.
  assign in_ready  = (state_q == IDLE);
  assign stall     = (state_q != IDLE);
  assign out_valid = (state_q == RESP);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign m_req     = (state_q == REQ);
  assign m_we      = m_req & we_q;
  assign m_addr    = m_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign m_wdata   = m_req ? lane_wdata : 32'h0;
  assign m_be      = m_req ? lane_be : 4'h0;

endmodule

// File: tb/tb_ydm_stage.sv
// Scoreboard bench for ydm_stage: expected results are queued at accept and
// checked when out_valid fires; latency and bus fields are checked inline.
module tb_ydm_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        out_valid;
  logic [31:0] rdata;
  logic        err;
  logic        stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    string       nm;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ydm_stage #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .wdata(wdata), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .out_valid(out_valid), .rdata(rdata), .err(err),
    .stall(stall), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  // Result monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_valid: got out_valid=1 rdata=%h err=%b, expected no result", rdata, err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rdata !== e.rd || err !== e.er) begin
          fails++;
          $display("FAIL %s result: got rdata=%h err=%b, expected rdata=%h err=%b", e.nm, rdata, err, e.rd, e.er);
        end
      end
    end
  end

  // One request; waits<0 means the bus never acks.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int waits, input logic [31:0] brd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic exp_bus, input logic [3:0] exp_be,
                       input logic [31:0] exp_addr, input logic chk_wd,
                       input logic [31:0] exp_wd, input int exp_lat,
                       input string nm);
    int cyc;
    int reqs;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s in_ready: got %b, expected 1", nm, in_ready);
    end
    e.rd = exp_rd; e.er = exp_err; e.nm = nm;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    cyc = 1;
    tests++;
    if (stall !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s stall_cycle1: got stall=%b in_ready=%b, expected 1/0", nm, stall, in_ready);
    end
    if (exp_bus) begin
      tests++;
      if (m_req !== 1'b1 || m_we !== wr || m_be !== exp_be || m_addr !== exp_addr ||
          (chk_wd && m_wdata !== exp_wd)) begin
        fails++;
        $display("FAIL %s bus: got req=%b we=%b be=%b addr=%h wdata=%h, expected req=1 we=%b be=%b addr=%h wdata=%h",
                 nm, m_req, m_we, m_be, m_addr, m_wdata, wr, exp_be, exp_addr, exp_wd);
      end
      if (waits < 0) begin
        reqs = 0;
        while (m_req === 1'b1 && cyc < 60) begin
          reqs++;
          @(negedge clk);
          cyc++;
        end
        tests++;
        if (reqs !== 15) begin
          fails++;
          $display("FAIL %s timeout_req_cycles: got %0d, expected 15", nm, reqs);
        end
      end else begin
        while (cyc < 1 + waits) begin
          @(negedge clk);
          cyc++;
        end
        tests++;
        if (m_req !== 1'b1 || m_be !== exp_be || m_addr !== exp_addr) begin
          fails++;
          $display("FAIL %s bus_hold: got req=%b be=%b addr=%h, expected req=1 be=%b addr=%h",
                   nm, m_req, m_be, m_addr, exp_be, exp_addr);
        end
        m_ack = 1'b1; m_rdata = brd;
        @(negedge clk);
        cyc++;
        m_ack = 1'b0; m_rdata = 32'h0;
      end
    end else begin
      tests++;
      if (m_req !== 1'b0) begin
        fails++;
        $display("FAIL %s no_bus: got m_req=%b, expected 0", nm, m_req);
      end
    end
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc !== exp_lat || stall !== 1'b1) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles stall=%b, expected %0d cycles stall=1", nm, cyc, stall, exp_lat);
    end
  endtask

  task automatic test_reset();
    tests++;
    if (in_ready !== 1'b1 || stall !== 1'b0 || out_valid !== 1'b0 || m_req !== 1'b0 || m_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy=%b stall=%b ov=%b req=%b we=%b, expected 1/0/0/0/0",
               in_ready, stall, out_valid, m_req, m_we);
    end
    tests++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_be !== 4'h0 || rdata !== 32'h0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%b rdata=%h err=%b, expected all 0",
               m_addr, m_wdata, m_be, rdata, err);
    end
  endtask

  task automatic test_store();
    do_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 32'h0, 32'h0, 0, 1, 4'b1111, 32'h100, 1, 32'hDEADBEEF, 5, "sw_wait3");
    do_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0, 32'h0, 0, 1, 4'b1100, 32'h100, 1, 32'hABCDABCD, 2, "sh_hi");
    do_op(0, 1, 3'b000, 32'h101, 32'h00000055, 1, 32'h0, 32'h0, 0, 1, 4'b0010, 32'h100, 1, 32'h55555555, 3, "sb_lane1");
  endtask

  task automatic test_load();
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF0000, 32'hFFFFFF80, 0, 1, 4'b1000, 32'h100, 0, 32'h0, 2, "lb_lane3");
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF0000, 32'h00000080, 0, 1, 4'b1000, 32'h100, 0, 32'h0, 2, "lbu_lane3");
    do_op(1, 0, 3'b101, 32'h102, 32'h0, 2, 32'hBEEF0000, 32'h0000BEEF, 0, 1, 4'b1100, 32'h100, 0, 32'h0, 4, "lhu_hi");
    do_op(1, 0, 3'b001, 32'h200, 32'h0, 0, 32'h00008001, 32'hFFFF8001, 0, 1, 4'b0011, 32'h200, 0, 32'h0, 2, "lh_lo");
    do_op(1, 0, 3'b010, 32'h204, 32'h0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1, 4'b1111, 32'h204, 0, 32'h0, 2, "lw");
  endtask

  task automatic test_misalign();
`ifdef YDM_MISALIGN_CHK_EN
    do_op(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h0, 1, "lw_misalign");
    do_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h0, 1, "lh_misalign");
`else
    do_op(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h12345678, 32'h12345678, 0, 1, 4'b1111, 32'h100, 0, 32'h0, 2, "lw_unaligned");
    do_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h00007FFF, 32'h00007FFF, 0, 1, 4'b0011, 32'h100, 0, 32'h0, 2, "lh_unaligned");
`endif
  endtask

  task automatic test_nonmem_err();
    do_op(0, 0, 3'b010, 32'h300, 32'h1, 0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, "nonmem");
    do_op(1, 1, 3'b010, 32'h300, 32'h1, 0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h0, 1, "rd_and_wr");
    do_op(1, 0, 3'b011, 32'h300, 32'h1, 0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h0, 1, "ld_f3_011");
    do_op(0, 1, 3'b100, 32'h300, 32'h1, 0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h0, 0, 32'h0, 1, "st_f3_100");
  endtask

  task automatic test_timeout();
    do_op(1, 0, 3'b010, 32'h400, 32'h0, -1, 32'h0, 32'h0, 1, 1, 4'b1111, 32'h400, 0, 32'h0, 16, "timeout");
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_stall_release: got stall=%b in_ready=%b, expected 0/1", stall, in_ready);
    end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'h0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || m_req !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL stray_ack: got rdy=%b req=%b stall=%b, expected 1/0/0", in_ready, m_req, stall);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    tests++;
    if (m_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: got m_req=%b, expected 1", m_req);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (m_req !== 1'b0 || stall !== 1'b0 || m_be !== 4'h0) begin
      fails++;
      $display("FAIL rst_mid_async: got req=%b stall=%b be=%b, expected 0/0/0", m_req, stall, m_be);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || sb_q.size() != 0) begin
      fails++;
      $display("FAIL rst_mid_idle: got in_ready=%b queued=%0d, expected 1/0", in_ready, sb_q.size());
    end
    do_op(1, 0, 3'b010, 32'h500, 32'h0, 1, 32'h0BADC0DE, 32'h0BADC0DE, 0, 1, 4'b1111, 32'h500, 0, 32'h0, 3, "after_reset");
  endtask

  initial begin
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_store();
    test_load();
    test_misalign();
    test_nonmem_err();
    test_timeout();
    test_stray_ack();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
